// File: rtl/sb_rx_deserializer_if.sv
// ---------------------------------------------------------------------------
// sb_rx_deserializer_if
// Packet delivery interface between the sideband receive path and the
// logical layer.
//   data_o   64  packet at the head of the receive FIFO
//   valid_o   1  a packet is available on data_o
//   ready_i   1  consumer accepts data_o
// Handshake: a transfer happens at every clock edge where valid_o && ready_i.
// While valid_o=1 and ready_i=0, data_o is held stable. valid_o never
// depends on ready_i.
// Modports:
//   master - the deserializer (drives data_o/valid_o, observes ready_i)
//   slave  - the consumer (observes data_o/valid_o, drives ready_i)
// ---------------------------------------------------------------------------
interface sb_rx_deserializer_if;
    logic [63:0] data_o;
    logic        valid_o;
    logic        ready_i;

    modport master (output data_o, output valid_o, input ready_i);
    modport slave  (input data_o, input valid_o, output ready_i);
endinterface

// File: rtl/sb_rx_deserializer.sv
// ---------------------------------------------------------------------------
// sb_rx_deserializer
// Sideband receive path. Samples dataPin_i on every cycle clkPin_i is high,
// assembles 64-bit packets LSB-first, checks the all-low gap that must
// follow each packet, and buffers finished packets in a small FIFO that the
// logical layer drains through a valid/ready handshake.
// Ports:
//   clk_800MHz   in   core clock
//   reset        in   asynchronous active-low reset
//   dataPin_i    in   serial sideband data
//   clkPin_i     in   forwarded clock active this cycle (bit/gap slot valid)
//   enable_i     in   1 = store packets, 0 = receive and discard
//   rx           if   packet delivery (data_o / valid_o / ready_i)
//   overflow_o   out  sticky: a packet was dropped because the FIFO was full
//   frame_err_o  out  one-cycle pulse per framing violation
//   busy_o       out  receiver is not idle
//   state_o      out  current receiver state (IDLE=0, RECEIVING=1, GAP=2)
// ---------------------------------------------------------------------------
module sb_rx_deserializer #(
    parameter int buffer_size = 4,
    parameter int GAP_CYCLES  = 32
) (
    input  logic                       clk_800MHz,
    input  logic                       reset,
    input  logic                       dataPin_i,
    input  logic                       clkPin_i,
    input  logic                       enable_i,
    sb_rx_deserializer_if.master       rx,
    output logic                       overflow_o,
    output logic                       frame_err_o,
    output logic                       busy_o,
    output logic [1:0]                 state_o
);
    localparam int AW = $clog2(buffer_size);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECEIVING = 2'd1,
        GAP       = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    bit_ctr_q, bit_ctr_d;
    logic [GW-1:0] gap_ctr_q, gap_ctr_d;
    logic          frame_err_q, frame_err_d;
    logic          push_cycle;

    // Bit 63 is never stored here: it is taken straight from the pin in the
    // push cycle.
    logic [62:0]   shift_q;

    logic [63:0]   mem [buffer_size];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;

    logic          fifo_valid, fifo_full, do_push, do_pop, push_ok, ovf_set;

    // ---------------- receiver FSM ----------------
    always_ff @(posedge clk_800MHz or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_ctr_q   <= '0;
            gap_ctr_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_ctr_q   <= bit_ctr_d;
            gap_ctr_q   <= gap_ctr_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_ctr_d   = bit_ctr_q;
        gap_ctr_d   = gap_ctr_q;
        frame_err_d = 1'b0;
        push_cycle  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clkPin_i) begin
                    state_d   = RECEIVING;
                    bit_ctr_d = 6'd1;
                end
            end
            RECEIVING: begin
                if (!clkPin_i) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                    bit_ctr_d   = '0;
                end else if (bit_ctr_q == 6'd63) begin
                    push_cycle = 1'b1;
                    state_d    = GAP;
                    bit_ctr_d  = '0;
                    gap_ctr_d  = '0;
                end else begin
                    bit_ctr_d = bit_ctr_q + 6'd1;
                end
            end
            GAP: begin
                if (!clkPin_i) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                    gap_ctr_d   = '0;
                end else begin
                    // A high gap bit is flagged but the gap keeps running.
                    frame_err_d = dataPin_i;
                    if (gap_ctr_q == GW'(GAP_CYCLES - 1)) begin
                        state_d   = IDLE;
                        gap_ctr_d = '0;
                    end else begin
                        gap_ctr_d = gap_ctr_q + GW'(1);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                bit_ctr_d = '0;
                gap_ctr_d = '0;
            end
        endcase
    end

    // In IDLE bit_ctr is 0, so the same write covers bit0.
    always_ff @(posedge clk_800MHz or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
        end else if (clkPin_i && (state_q == IDLE ||
                     (state_q == RECEIVING && bit_ctr_q != 6'd63))) begin
            shift_q[bit_ctr_q] <= dataPin_i;
        end
    end

    // ---------------- packet FIFO ----------------
    assign fifo_valid = (count_q != '0);
    assign fifo_full  = (count_q == (AW + 1)'(buffer_size));
    assign do_push    = push_cycle && enable_i;
    assign do_pop     = fifo_valid && rx.ready_i;
    // When full, a push only fits if the head leaves in the same cycle.
    assign push_ok    = do_push && (!fifo_full || do_pop);
    assign ovf_set    = do_push && fifo_full && !do_pop;

    always_ff @(posedge clk_800MHz) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= {dataPin_i, shift_q};
        end
    end

    always_ff @(posedge clk_800MHz or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (ovf_set) overflow_q <= 1'b1;
        end
    end

    // Head entry is masked to zero when empty so data_o reads 0 in reset.
    assign rx.data_o  = fifo_valid ? mem[rd_ptr_q] : '0;
    assign rx.valid_o = fifo_valid;

    assign overflow_o  = overflow_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q != IDLE);
    assign state_o     = state_q;
endmodule
